// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use stall FSM, branch flush, optional ME/WB forwarding (macro HCU_FORWARD_EN)
module hazard_control_unit #(
  parameter int REG_AW         = 5,
  parameter int LOAD_STALL_CYC = 1,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_de,
  input  logic [REG_AW-1:0] rs2_de,
  input  logic              rs1_use_de,
  input  logic              rs2_use_de,
  input  logic [REG_AW-1:0] rs1_ex,
  input  logic [REG_AW-1:0] rs2_ex,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic              RegWr_ex,
  input  logic              DMRd_ex,
  input  logic [REG_AW-1:0] rd_me,
  input  logic              RegWr_me,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic              RegWr_wb,
  input  logic              br_taken_ex,
  output logic              pc_fe,
  output logic              pc_inc_de,
  output logic              clr,
  output logic              flush_de,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_count
);
  typedef enum logic {RUN, STALL} state_t;
  localparam logic [3:0] STALL_INIT = 4'(LOAD_STALL_CYC - 1);
  state_t           r_state, w_next;
  logic [3:0]       r_cnt, w_cnt_next;
  logic [CNT_W-1:0] r_stall_count;
  logic             w_src_ex, w_lu;
  assign w_src_ex = (rs1_use_de && rs1_de == rd_ex) || (rs2_use_de && rs2_de == rd_ex);
`ifdef HCU_FORWARD_EN
  logic w_unused;
  assign w_unused = RegWr_ex;
  assign w_lu = DMRd_ex && rd_ex != '0 && w_src_ex;
  // ME result wins over WB; x0 is never forwarded; reset forces register-file source
  always_comb begin
    fwd_a = rst ? 2'b00 :
            (RegWr_me && rd_me != '0 && rd_me == rs1_ex) ? 2'b10 :
            (RegWr_wb && rd_wb != '0 && rd_wb == rs1_ex) ? 2'b01 : 2'b00;
    fwd_b = rst ? 2'b00 :
            (RegWr_me && rd_me != '0 && rd_me == rs2_ex) ? 2'b10 :
            (RegWr_wb && rd_wb != '0 && rd_wb == rs2_ex) ? 2'b01 : 2'b00;
  end
`else
  logic w_src_me, w_unused;
  assign w_unused = ^{rs1_ex, rs2_ex, rd_wb, RegWr_wb};
  assign w_src_me = (rs1_use_de && rs1_de == rd_me) || (rs2_use_de && rs2_de == rd_me);
  assign w_lu = ((DMRd_ex || RegWr_ex) && rd_ex != '0 && w_src_ex) ||
                (RegWr_me && rd_me != '0 && w_src_me);
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif
  // state and bubble counter; reset aborts any stall in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end
  // next state and pipeline controls; STALL ignores branches and new hazards
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    pc_fe      = 1'b1;
    pc_inc_de  = 1'b1;
    clr        = 1'b0;
    flush_de   = 1'b0;
    if (rst) begin
      pc_fe     = 1'b0;
      pc_inc_de = 1'b0;
      clr       = 1'b1;
    end else if (r_state == STALL) begin
      pc_fe      = 1'b0;
      pc_inc_de  = 1'b0;
      clr        = 1'b1;
      w_cnt_next = r_cnt - 4'd1;
      w_next     = (r_cnt == 4'd1) ? RUN : STALL;
    end else if (br_taken_ex) begin
      flush_de = 1'b1;
      clr      = 1'b1;
    end else if (w_lu) begin
      pc_fe     = 1'b0;
      pc_inc_de = 1'b0;
      clr       = 1'b1;
      if (LOAD_STALL_CYC > 1) begin
        w_next     = STALL;
        w_cnt_next = STALL_INIT;
      end
    end
  end
  // saturating count of cycles with the PC frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_count <= '0;
    else if (!pc_fe && r_stall_count != '1)
      r_stall_count <= r_stall_count + CNT_W'(1);
  end
  assign stall_count = r_stall_count;
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed checks of stall, flush, reset and forwarding behaviour
module tb_hazard_control_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_de, rs2_de, rs1_ex, rs2_ex, rd_ex, rd_me, rd_wb;
  logic       rs1_use_de, rs2_use_de, RegWr_ex, DMRd_ex, RegWr_me, RegWr_wb, br_taken_ex;
  logic        pc1, inc1, clr1, fl1, pc3, inc3, clr3, fl3, pc4, inc4, clr4, fl4;
  logic [1:0]  fa1, fb1, fa3, fb3, fa4, fb4;
  logic [31:0] sc1, sc4;
  logic [1:0]  sc3;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.LOAD_STALL_CYC(1)) u1 (
    .clk(clk), .rst(rst), .rs1_de(rs1_de), .rs2_de(rs2_de), .rs1_use_de(rs1_use_de),
    .rs2_use_de(rs2_use_de), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .RegWr_ex(RegWr_ex), .DMRd_ex(DMRd_ex), .rd_me(rd_me), .RegWr_me(RegWr_me),
    .rd_wb(rd_wb), .RegWr_wb(RegWr_wb), .br_taken_ex(br_taken_ex), .pc_fe(pc1),
    .pc_inc_de(inc1), .clr(clr1), .flush_de(fl1), .fwd_a(fa1), .fwd_b(fb1), .stall_count(sc1));
  hazard_control_unit #(.LOAD_STALL_CYC(3), .CNT_W(2)) u3 (
    .clk(clk), .rst(rst), .rs1_de(rs1_de), .rs2_de(rs2_de), .rs1_use_de(rs1_use_de),
    .rs2_use_de(rs2_use_de), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .RegWr_ex(RegWr_ex), .DMRd_ex(DMRd_ex), .rd_me(rd_me), .RegWr_me(RegWr_me),
    .rd_wb(rd_wb), .RegWr_wb(RegWr_wb), .br_taken_ex(br_taken_ex), .pc_fe(pc3),
    .pc_inc_de(inc3), .clr(clr3), .flush_de(fl3), .fwd_a(fa3), .fwd_b(fb3), .stall_count(sc3));
  hazard_control_unit #(.LOAD_STALL_CYC(4)) u4 (
    .clk(clk), .rst(rst), .rs1_de(rs1_de), .rs2_de(rs2_de), .rs1_use_de(rs1_use_de),
    .rs2_use_de(rs2_use_de), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .RegWr_ex(RegWr_ex), .DMRd_ex(DMRd_ex), .rd_me(rd_me), .RegWr_me(RegWr_me),
    .rd_wb(rd_wb), .RegWr_wb(RegWr_wb), .br_taken_ex(br_taken_ex), .pc_fe(pc4),
    .pc_inc_de(inc4), .clr(clr4), .flush_de(fl4), .fwd_a(fa4), .fwd_b(fb4), .stall_count(sc4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle();
    {rs1_de, rs2_de, rs1_ex, rs2_ex, rd_ex, rd_me, rd_wb} = '0;
    {rs1_use_de, rs2_use_de, RegWr_ex, DMRd_ex, RegWr_me, RegWr_wb, br_taken_ex} = '0;
  endtask

  task automatic load_use();
    DMRd_ex = 1'b1; RegWr_ex = 1'b1; rd_ex = 5'd5; rs1_de = 5'd5; rs1_use_de = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_pc_fe", pc1, 0); chk("rst_pc_inc", inc1, 0); chk("rst_clr", clr1, 1);
    chk("rst_flush", fl1, 0); chk("rst_fwd_a", fa1, 0); chk("rst_fwd_b", fb1, 0);
    chk("rst_count", sc1, 0); chk("rst_pc_fe_u4", pc4, 0);
    step(); rst = 1'b0;
    smp(); chk("post_rst_pc_fe", pc4, 1); chk("post_rst_clr", clr4, 0);
    // single load-use: 1, 3 and 4 bubbles
    step(); load_use();
    smp(); chk("lu_pc_fe_u1", pc1, 0); chk("lu_clr_u1", clr1, 1); chk("lu_inc_u1", inc1, 0);
    chk("lu_flush_u1", fl1, 0); chk("lu_pc_fe_u3", pc3, 0); chk("lu_pc_fe_u4", pc4, 0);
    step(); DMRd_ex = 0; RegWr_ex = 0; rd_ex = 0;
    smp(); chk("c1_pc_fe_u1", pc1, 1); chk("c1_count_u1", sc1, 1);
    chk("c1_pc_fe_u3", pc3, 0); chk("c1_clr_u3", clr3, 1); chk("c1_pc_fe_u4", pc4, 0);
    step(); br_taken_ex = 1;
    smp(); chk("c2_pc_fe_u3", pc3, 0); chk("c2_flush_u3", fl3, 0);
    chk("c2_flush_u1", fl1, 1); chk("c2_pc_fe_u1", pc1, 1); chk("c2_pc_fe_u4", pc4, 0);
    step(); br_taken_ex = 0;
    smp(); chk("c3_pc_fe_u3", pc3, 1); chk("c3_count_u3", sc3, 3); chk("c3_pc_fe_u4", pc4, 0);
    step();
    smp(); chk("c4_pc_fe_u4", pc4, 1); chk("c4_count_u4", sc4, 4); chk("c4_count_u1", sc1, 1);
    // held hazard: back-to-back stalls and 2-bit saturation in u3
    step(); load_use();
    smp(); chk("bb0_pc_fe_u3", pc3, 0);
    step(); step();
    step();
    smp(); chk("bb3_pc_fe_u3", pc3, 0); chk("bb3_count_sat_u3", sc3, 3); chk("bb3_pc_fe_u1", pc1, 0);
    step(); idle();
    smp(); chk("bb4_pc_fe_u1", pc1, 1); chk("bb4_count_u1", sc1, 5);
    repeat (4) step();
    // x0 load and unused rs2 never stall
    step(); DMRd_ex = 1; RegWr_ex = 1; rd_ex = 0; rs1_de = 0; rs1_use_de = 1;
    smp(); chk("x0_pc_fe", pc1, 1); chk("x0_clr", clr1, 0);
    step(); rd_ex = 5; rs1_de = 3; rs2_de = 5; rs2_use_de = 0;
    smp(); chk("nouse_pc_fe_u1", pc1, 1); chk("nouse_pc_fe_u4", pc4, 1);
    // branch wins over load-use
    step(); idle(); load_use(); br_taken_ex = 1;
    smp(); chk("br_lu_flush", fl3, 1); chk("br_lu_clr", clr3, 1);
    chk("br_lu_pc_fe", pc3, 1); chk("br_lu_inc", inc3, 1);
    step(); idle();
    smp(); chk("br_after_pc_fe_u3", pc3, 1); chk("br_after_pc_fe_u4", pc4, 1);
    // forwarding, or widened RAW stalls without it
    step(); rs1_ex = 7; rd_me = 7; rd_wb = 7; RegWr_me = 1; RegWr_wb = 1;
    smp();
`ifdef HCU_FORWARD_EN
    chk("fwd_a_me", fa1, 2'b10);
    step(); RegWr_me = 0;
    smp(); chk("fwd_a_wb", fa1, 2'b01);
    step(); rs2_ex = 9; rd_me = 0; RegWr_me = 1; rd_wb = 9;
    smp(); chk("fwd_b_wb", fb1, 2'b01); chk("fwd_a_none", fa1, 2'b00);
    step(); idle(); RegWr_ex = 1; rd_ex = 6; rs2_de = 6; rs2_use_de = 1;
    smp(); chk("alu_raw_no_stall", pc1, 1);
`else
    chk("fwd_a_tied", fa1, 0); chk("fwd_b_tied", fb1, 0);
    step(); idle(); RegWr_ex = 1; rd_ex = 6; rs2_de = 6; rs2_use_de = 1;
    smp(); chk("raw_ex_stall", pc1, 0);
    step(); idle(); RegWr_me = 1; rd_me = 6; rs2_de = 6; rs2_use_de = 1;
    smp(); chk("raw_me_stall", pc1, 0);
    step(); idle(); RegWr_wb = 1; rd_wb = 6; rs2_de = 6; rs2_use_de = 1;
    smp(); chk("raw_wb_no_stall", pc1, 1);
`endif
    step(); idle();
    repeat (5) step();
    // reset in the middle of a 4-cycle stall
    load_use();
    smp(); chk("rs_c0_pc_fe_u4", pc4, 0);
    step(); idle(); rst = 1;
    smp(); chk("rs_pc_fe_u4", pc4, 0); chk("rs_clr_u4", clr4, 1); chk("rs_inc_u4", inc4, 0);
    chk("rs_flush_u4", fl4, 0); chk("rs_count_u4", sc4, 0); chk("rs_fwd_a_u4", fa4, 0);
    step(); rst = 0;
    smp(); chk("rel_pc_fe_u4", pc4, 1); chk("rel_clr_u4", clr4, 0); chk("rel_count_u4", sc4, 0);
    step();
    smp(); chk("rel2_pc_fe_u4", pc4, 1); chk("rel2_count_u4", sc4, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
